// File: rtl/mtl2_pix_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mtl2_pix_fifo_ctrl_pkg : state codes and helpers shared by the pixel FIFO
//                          flow controller.
// Revision: 1.0
// ============================================================================
package mtl2_pix_fifo_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_FLUSH    = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_SOP = 3'd2;
    localparam logic [STATE_W-1:0] ST_PREFILL  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RUN      = 3'd4;

    localparam logic [7:0] UF_CNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == UF_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtl2_pix_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// mtl2_pix_fifo_ctrl_if : pixel stream sink, display read port and companion
//                         FIFO control/status bundle.
// Revision: 1.0
// ============================================================================
interface mtl2_pix_fifo_ctrl_if #(
    parameter int DATA_WIDTH  = 24,
    parameter int DATA_WIDTHU = 11
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sop;
    logic [DATA_WIDTH-1:0]  in_data;

    logic                   pix_req;
    logic                   pix_valid;

    logic                   fifo_aclr;
    logic                   fifo_wrreq;
    logic [DATA_WIDTH-1:0]  fifo_data;
    logic                   fifo_rdreq;
    logic [DATA_WIDTHU-1:0] fifo_usedw;
    logic                   fifo_empty;
    logic                   fifo_full;

    // Controller side
    modport master (
        input  in_valid, in_sop, in_data, pix_req,
               fifo_usedw, fifo_empty, fifo_full,
        output in_ready, pix_valid,
               fifo_aclr, fifo_wrreq, fifo_data, fifo_rdreq
    );

    // Stream source, display and FIFO side
    modport slave (
        output in_valid, in_sop, in_data, pix_req,
               fifo_usedw, fifo_empty, fifo_full,
        input  in_ready, pix_valid,
               fifo_aclr, fifo_wrreq, fifo_data, fifo_rdreq
    );

endinterface
`default_nettype wire

// File: rtl/mtl2_pix_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// mtl2_pix_fifo_ctrl : prefills the LCD line FIFO from an Avalon-ST stream,
//                      serves pixel reads, flushes and resyncs on underflow.
// Revision: 1.0
// ============================================================================
module mtl2_pix_fifo_ctrl
    import mtl2_pix_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int FIFO_DEPTH   = 1920,
    parameter int DATA_WIDTHU  = $clog2(FIFO_DEPTH),
    parameter int START_LEVEL  = 1024,
    parameter int HEADROOM     = 4,
    parameter int FLUSH_CYCLES = 4
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    input  wire logic               enable,
    input  wire logic               underflow_clr,
    output logic                    underflow,
    output logic [7:0]              underflow_cnt,
    output logic [STATE_W-1:0]      state_o,
    mtl2_pix_fifo_ctrl_if.master    bus
);

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES);
    localparam logic [FLUSH_W-1:0]     FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [DATA_WIDTHU-1:0] ROOM_LIMIT = DATA_WIDTHU'(FIFO_DEPTH - HEADROOM);
    localparam logic [DATA_WIDTHU-1:0] START_LVL  = DATA_WIDTHU'(START_LEVEL);

    logic [STATE_W-1:0]    state;
    logic [STATE_W-1:0]    state_nxt;
    logic [FLUSH_W-1:0]    flush_cnt;
    logic [FLUSH_W-1:0]    flush_cnt_nxt;
    logic                  aclr_reg;
    logic                  aclr_nxt;
    logic                  pix_valid_reg;
    logic                  room;
    logic                  uf_event;
    logic                  ready;
    logic [DATA_WIDTH-1:0] pass_data;

    // usedw trails a write by one cycle; the headroom margin covers that gap.
    assign room = !bus.fifo_full && (bus.fifo_usedw < ROOM_LIMIT);

    always_comb begin
        ready = 1'b0;
        case (state)
            ST_WAIT_SOP:        ready = 1'b1;
            ST_PREFILL, ST_RUN: ready = room;
            default:            ready = 1'b0;
        endcase
    end

    assign pass_data      = bus.in_data;
    assign bus.fifo_data  = pass_data;
    assign bus.in_ready   = ready;
    assign bus.fifo_wrreq = bus.in_valid && ready && ((state != ST_WAIT_SOP) || bus.in_sop);
    assign bus.fifo_rdreq = (state == ST_RUN) && bus.pix_req && !bus.fifo_empty;
    assign uf_event       = (state == ST_RUN) && bus.pix_req &&  bus.fifo_empty;

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = '0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) state_nxt = ST_WAIT_SOP;
                else                         flush_cnt_nxt = flush_cnt + 1'b1;
            end
            ST_WAIT_SOP: begin
                if (bus.in_valid && bus.in_sop) state_nxt = ST_PREFILL;
            end
            ST_PREFILL: begin
                if (bus.fifo_usedw >= START_LVL) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (uf_event) state_nxt = ST_FLUSH;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!enable) begin
            state_nxt     = ST_IDLE;
            flush_cnt_nxt = '0;
        end
    end

    // The final flush cycle drops aclr so the FIFO sees a clean release before the first write.
    assign aclr_nxt = (state_nxt == ST_IDLE) ||
                      ((state_nxt == ST_FLUSH) && (flush_cnt_nxt != FLUSH_LAST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            flush_cnt     <= '0;
            aclr_reg      <= 1'b1;
            pix_valid_reg <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= 8'd0;
        end else begin
            state         <= state_nxt;
            flush_cnt     <= flush_cnt_nxt;
            aclr_reg      <= aclr_nxt;
            pix_valid_reg <= bus.fifo_rdreq;
            if (uf_event) begin
                underflow     <= 1'b1;
                underflow_cnt <= sat_inc8(underflow_cnt);
            end else if (underflow_clr) begin
                underflow     <= 1'b0;
            end
        end
    end

    assign bus.fifo_aclr = aclr_reg;
    assign bus.pix_valid = pix_valid_reg;
    assign state_o       = state;

endmodule
`default_nettype wire

// File: tb/tb_mtl2_pix_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mtl2_pix_fifo_ctrl : controller paired with a behavioural same-clock FIFO,
//                         directed scenarios plus a random streaming phase.
// Revision: 1.0
// ============================================================================
module tb_mtl2_pix_fifo_ctrl;

    localparam int DW    = 24;
    localparam int DEPTH = 64;
    localparam int DWU   = 6;
    localparam int START = 32;
    localparam int HEAD  = 4;
    localparam int FLUSH = 4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FLUSH    = 3'd1;
    localparam logic [2:0] S_WAIT_SOP = 3'd2;
    localparam logic [2:0] S_PREFILL  = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;

    logic       clk           = 1'b0;
    logic       reset_n       = 1'b0;
    logic       enable        = 1'b0;
    logic       underflow_clr = 1'b0;
    logic       underflow;
    logic [7:0] underflow_cnt;
    logic [2:0] state_o;

    mtl2_pix_fifo_ctrl_if #(.DATA_WIDTH(DW), .DATA_WIDTHU(DWU)) bus ();

    mtl2_pix_fifo_ctrl #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .DATA_WIDTHU  (DWU),
        .START_LEVEL  (START),
        .HEADROOM     (HEAD),
        .FLUSH_CYCLES (FLUSH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .underflow_clr (underflow_clr),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt),
        .state_o       (state_o),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered usedw/flags, showahead off, cleared while aclr is high.
    logic [DW-1:0] mem [0:DEPTH-1];
    int            fcount = 0;
    int            wp     = 0;
    int            rp     = 0;
    logic [DW-1:0] fifo_q = '0;

    always @(posedge clk) begin
        if (bus.fifo_aclr) begin
            fcount <= 0;
            wp     <= 0;
            rp     <= 0;
        end else begin
            if (bus.fifo_wrreq && fcount < DEPTH) begin
                mem[wp] <= bus.fifo_data;
                wp      <= (wp + 1) % DEPTH;
            end
            if (bus.fifo_rdreq && fcount > 0) begin
                fifo_q <= mem[rp];
                rp     <= (rp + 1) % DEPTH;
            end
            fcount <= fcount + ((bus.fifo_wrreq && fcount < DEPTH) ? 1 : 0)
                             - ((bus.fifo_rdreq && fcount > 0) ? 1 : 0);
        end
    end

    assign bus.fifo_usedw = DWU'(fcount);
    assign bus.fifo_full  = (fcount == DEPTH);
    assign bus.fifo_empty = (fcount == 0);

    int n_checks = 0;
    int n_err    = 0;
    int pix_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted beats become expected pixels; a flush empties the model.
    logic [DW-1:0] exp_q [$];
    bit            synced = 1'b0;
    bit            mon_on = 1'b0;

    always @(negedge clk) begin
        bit exp_wr;
        if (mon_on) begin
            if (bus.pix_valid) begin
                pix_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_pix: actual=%0h expected=none at %0t", fifo_q, $time);
                end else begin
                    chk("pix_data", 32'(fifo_q), 32'(exp_q.pop_front()));
                end
            end
            exp_wr = bus.in_valid && bus.in_ready && (synced || bus.in_sop);
            chk("wrreq", 32'(bus.fifo_wrreq), 32'(exp_wr));
            chk("wr_while_full", 32'(bus.fifo_wrreq && bus.fifo_full), 32'd0);
            chk("rd_while_empty", 32'(bus.fifo_rdreq && bus.fifo_empty), 32'd0);
            if (exp_wr) begin
                exp_q.push_back(bus.in_data);
                synced = 1'b1;
            end
            if (bus.fifo_aclr) begin
                exp_q.delete();
                synced = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string name);
        int n = 0;
        while (state_o !== s && n < limit) begin
            tick();
            n++;
        end
        chk(name, 32'(state_o), 32'(s));
    endtask

    // From IDLE: aclr high for FLUSH-1 cycles, low for one, then WAIT_SOP.
    task automatic startup(input string tag);
        enable = 1'b1;
        tick();
        for (int i = 0; i < FLUSH; i++) begin
            chk({tag, "_flush_state"}, 32'(state_o), 32'(S_FLUSH));
            chk({tag, "_flush_aclr"}, 32'(bus.fifo_aclr), (i < FLUSH - 1) ? 32'd1 : 32'd0);
            tick();
        end
        chk({tag, "_wait_sop"}, 32'(state_o), 32'(S_WAIT_SOP));
        chk({tag, "_aclr_released"}, 32'(bus.fifo_aclr), 32'd0);
    endtask

    task automatic beat(input logic sop);
        bus.in_valid = 1'b1;
        bus.in_sop   = sop;
        bus.in_data  = DW'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        int start_cnt;
        int pix_base;
        int prev_u;
        int max_cnt;

        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_data  = '0;
        bus.pix_req  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_o), 32'(S_IDLE));
        chk("rst_aclr", 32'(bus.fifo_aclr), 32'd1);
        chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_uf_cnt", 32'(underflow_cnt), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        reset_n = 1'b1;
        tick();
        mon_on = 1'b1;
        chk("idle_hold", 32'(state_o), 32'(S_IDLE));

        // Scenario 1: startup sequence
        startup("s1");

        // Scenario 2: non-SOP beats dropped, SOP written, RUN after START words
        for (int i = 0; i < 5; i++) begin
            beat(1'b0);
            #1;
            chk("s2_drop", 32'(bus.fifo_wrreq), 32'd0);
            tick();
        end
        beat(1'b1);
        #1;
        chk("s2_sop_write", 32'(bus.fifo_wrreq), 32'd1);
        tick();
        chk("s2_prefill", 32'(state_o), 32'(S_PREFILL));
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            prev_u = fcount;
            beat(1'b0);
            tick();
            if (prev_u >= START) begin
                chk("s2_run_entry", 32'(state_o), 32'(S_RUN));
                done = 1'b1;
            end else if (state_o !== S_PREFILL) begin
                chk("s2_prefill_hold", 32'(state_o), 32'(S_PREFILL));
                done = 1'b1;
            end
        end
        chk("s2_reached_run", 32'(done), 32'd1);

        // Scenario 3: no reads, write gating at the headroom level
        max_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            beat(1'b0);
            #1;
            chk("s3_ready", 32'(bus.in_ready), 32'(fcount < DEPTH - HEAD && fcount < DEPTH));
            tick();
            if (fcount > max_cnt) max_cnt = fcount;
        end
        chk("s3_ready_low", 32'(bus.in_ready), 32'd0);
        chk("s3_level", 32'(max_cnt >= DEPTH - HEAD && max_cnt <= DEPTH - HEAD + 1), 32'd1);

        // Scenario 4: source stalled, drain to underflow
        bus.in_valid = 1'b0;
        bus.pix_req  = 1'b1;
        start_cnt    = fcount;
        pix_base     = pix_cnt;
        wait_state(S_FLUSH, 200, "s4_flush");
        chk("s4_reads", 32'(pix_cnt - pix_base), 32'(start_cnt));
        chk("s4_pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("s4_underflow", 32'(underflow), 32'd1);
        chk("s4_uf_cnt", 32'(underflow_cnt), 32'd1);
        chk("s4_aclr", 32'(bus.fifo_aclr), 32'd1);
        bus.pix_req = 1'b0;

        // Random streaming: reads only requested when the FIFO model holds data
        wait_state(S_WAIT_SOP, 20, "rand_wait_sop");
        pix_base = pix_cnt;
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid = ($urandom_range(99) < 85);
            bus.in_sop   = ($urandom_range(99) < 4);
            bus.in_data  = DW'($urandom);
            bus.pix_req  = ($urandom_range(1) == 1) && (fcount > 0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.pix_req  = 1'b0;
        chk("rand_run", 32'(state_o), 32'(S_RUN));
        chk("rand_no_uf", 32'(underflow_cnt), 32'd1);
        chk("rand_pix_seen", 32'(pix_cnt - pix_base > 100), 32'd1);

        // Scenario 5: clear coincides with the second underflow
        bus.pix_req = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (state_o == S_RUN && fcount == 0) begin
                underflow_clr = 1'b1;
                done = 1'b1;
            end
            tick();
            underflow_clr = 1'b0;
        end
        chk("s5_found", 32'(done), 32'd1);
        chk("s5_underflow_set_wins", 32'(underflow), 32'd1);
        chk("s5_uf_cnt", 32'(underflow_cnt), 32'd2);
        chk("s5_flush", 32'(state_o), 32'(S_FLUSH));
        bus.pix_req   = 1'b0;
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        chk("s5_clr", 32'(underflow), 32'd0);
        chk("s5_cnt_kept", 32'(underflow_cnt), 32'd2);

        // Scenario 6: enable dropped mid-prefill, then restart
        wait_state(S_WAIT_SOP, 20, "s6_wait_sop");
        beat(1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            beat(1'b0);
            tick();
        end
        chk("s6_prefill", 32'(state_o), 32'(S_PREFILL));
        enable = 1'b0;
        tick();
        chk("s6_idle", 32'(state_o), 32'(S_IDLE));
        chk("s6_in_ready", 32'(bus.in_ready), 32'd0);
        chk("s6_aclr", 32'(bus.fifo_aclr), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        startup("s6");

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
